// File: rtl/gfx256_blend_pipe.sv
// gfx256_blend_pipe: per-pixel blender between the fragment generator and the
// render stage. Fragments are queued with their latched blend mode and
// effective alpha; target reads are issued in order and their data is queued
// separately, so up to FIFO_DEPTH reads may be outstanding.
module gfx256_blend_pipe #(
   parameter int unsigned POINT_W    = 16,
   parameter int unsigned CH_W       = 8,
   parameter int unsigned NCH        = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [1:0]              mode_i,
   input  logic [7:0]              global_alpha_i,
   input  logic                    frag_valid_i,
   output logic                    frag_ready_o,
   input  logic [POINT_W-1:0]      frag_x_i,
   input  logic [POINT_W-1:0]      frag_y_i,
   input  logic [POINT_W-1:0]      frag_z_i,
   input  logic [7:0]              frag_alpha_i,
   input  logic [NCH*CH_W-1:0]     frag_color_i,
   output logic                    rd_req_o,
   input  logic                    rd_ready_i,
   output logic [POINT_W-1:0]      rd_x_o,
   output logic [POINT_W-1:0]      rd_y_o,
   input  logic                    rd_valid_i,
   input  logic [NCH*CH_W-1:0]     rd_data_i,
   output logic                    pix_valid_o,
   input  logic                    pix_ready_i,
   output logic [POINT_W-1:0]      pix_x_o,
   output logic [POINT_W-1:0]      pix_y_o,
   output logic [POINT_W-1:0]      pix_z_o,
   output logic [NCH*CH_W-1:0]     pix_color_o,
   output logic                    busy_o
);

   localparam int unsigned COL_W = NCH * CH_W;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW    = CH_W + 9;
   localparam int unsigned PRW   = 2 * CH_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      MODE_REPLACE = 2'b00,
      MODE_ALPHA   = 2'b01,
      MODE_ADD     = 2'b10,
      MODE_MUL     = 2'b11
   } mode_e;

   // One channel of the blend. Alpha rounding adds 127 before dividing by 255;
   // an exact .5 remainder cannot occur with an odd divisor, so this is
   // round-half-up. a=255 and a=0 reduce to s and d exactly.
   function automatic logic [CH_W-1:0] blend_ch(input mode_e mode,
                                                input logic [CH_W-1:0] s,
                                                input logic [CH_W-1:0] d,
                                                input logic [7:0] a);
      logic [PW-1:0]  num;
      logic [CH_W:0]  sum;
      logic [PRW-1:0] prod;
      num  = PW'(s) * PW'(a) + PW'(d) * PW'(8'd255 - a) + PW'(127);
      sum  = {1'b0, s} + {1'b0, d};
      prod = PRW'(s) * PRW'(d);
      blend_ch = s;
      case (mode)
         MODE_REPLACE: blend_ch = s;
         MODE_ALPHA:   blend_ch = CH_W'(num / PW'(255));
         MODE_ADD:     blend_ch = sum[CH_W] ? '1 : sum[CH_W-1:0];
         default: begin
            if (s == '1)      blend_ch = d;
            else if (d == '1) blend_ch = s;
            else              blend_ch = CH_W'(prod >> CH_W);
         end
      endcase
   endfunction

   // Fragment FIFO storage and control
   logic [POINT_W-1:0] r_fx    [FIFO_DEPTH];
   logic [POINT_W-1:0] r_fy    [FIFO_DEPTH];
   logic [POINT_W-1:0] r_fz    [FIFO_DEPTH];
   logic [COL_W-1:0]   r_fs    [FIFO_DEPTH];
   mode_e              r_fmode [FIFO_DEPTH];
   logic               r_fneed [FIFO_DEPTH];
   logic [7:0]         r_fa    [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_fwptr, r_frptr;
   logic [CNT_W-1:0]   r_fcnt;

   // Read-data FIFO storage and control
   logic [COL_W-1:0]   r_dmem  [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_dwptr, r_drptr;
   logic [CNT_W-1:0]   r_dcnt;

   // Output register
   logic               r_pix_valid;
   logic [POINT_W-1:0] r_pix_x, r_pix_y, r_pix_z;
   logic [COL_W-1:0]   r_pix_col;

   logic               w_need_rd, w_frag_full, w_push, w_pop;
   logic               w_head_need, w_rd_push, w_rd_pop;
   logic [7:0]         w_frag_a;
   logic [COL_W-1:0]   w_blend;

   assign w_need_rd   = (mode_i != 2'b00);
   assign w_frag_full = (r_fcnt == DEPTH_C);
   assign rd_req_o    = frag_valid_i & w_need_rd & ~w_frag_full;
   assign frag_ready_o = ~w_frag_full & (~w_need_rd | rd_ready_i);
   assign w_push      = frag_valid_i & frag_ready_o;
   assign rd_x_o      = frag_x_i;
   assign rd_y_o      = frag_y_i;
   assign w_frag_a    = 8'((16'(frag_alpha_i) * 16'(global_alpha_i) + 16'd127) / 16'd255);

   assign w_head_need = r_fneed[r_frptr];
   assign w_pop       = (r_fcnt != '0) & (~w_head_need | (r_dcnt != '0)) &
                        (~r_pix_valid | pix_ready_i);
   assign w_rd_push   = rd_valid_i & (r_dcnt != DEPTH_C);
   assign w_rd_pop    = w_pop & w_head_need;

   assign pix_valid_o = r_pix_valid;
   assign pix_x_o     = r_pix_x;
   assign pix_y_o     = r_pix_y;
   assign pix_z_o     = r_pix_z;
   assign pix_color_o = r_pix_col;
   assign busy_o      = (r_fcnt != '0) | r_pix_valid;

   // Blend the head fragment against the head read data, channel by channel
   always_comb begin
      w_blend = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         w_blend[c*CH_W +: CH_W] = blend_ch(r_fmode[r_frptr],
                                            r_fs[r_frptr][c*CH_W +: CH_W],
                                            r_dmem[r_drptr][c*CH_W +: CH_W],
                                            r_fa[r_frptr]);
      end
   end

   // Fragment FIFO payload write
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fx[r_fwptr]    <= frag_x_i;
         r_fy[r_fwptr]    <= frag_y_i;
         r_fz[r_fwptr]    <= frag_z_i;
         r_fs[r_fwptr]    <= frag_color_i;
         r_fmode[r_fwptr] <= mode_e'(mode_i);
         r_fneed[r_fwptr] <= w_need_rd;
         r_fa[r_fwptr]    <= w_frag_a;
      end
   end

   // Fragment FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_fwptr <= '0;
         r_frptr <= '0;
         r_fcnt  <= '0;
      end else begin
         if (w_push) r_fwptr <= r_fwptr + PTR_W'(1);
         if (w_pop)  r_frptr <= r_frptr + PTR_W'(1);
         if (w_push && !w_pop)      r_fcnt <= r_fcnt + CNT_W'(1);
         else if (!w_push && w_pop) r_fcnt <= r_fcnt - CNT_W'(1);
      end
   end

   // Read-data FIFO payload write
   always_ff @(posedge clk_i) begin
      if (w_rd_push) r_dmem[r_dwptr] <= rd_data_i;
   end

   // Read-data FIFO pointers and occupancy; rd_valid_i is ignored in reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_dwptr <= '0;
         r_drptr <= '0;
         r_dcnt  <= '0;
      end else begin
         if (w_rd_push) r_dwptr <= r_dwptr + PTR_W'(1);
         if (w_rd_pop)  r_drptr <= r_drptr + PTR_W'(1);
         if (w_rd_push && !w_rd_pop)      r_dcnt <= r_dcnt + CNT_W'(1);
         else if (!w_rd_push && w_rd_pop) r_dcnt <= r_dcnt - CNT_W'(1);
      end
   end

   // Output register: loads on pop, holds until the render stage accepts
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pix_valid <= 1'b0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_pix_z     <= '0;
         r_pix_col   <= '0;
      end else if (w_pop) begin
         r_pix_valid <= 1'b1;
         r_pix_x     <= r_fx[r_frptr];
         r_pix_y     <= r_fy[r_frptr];
         r_pix_z     <= r_fz[r_frptr];
         r_pix_col   <= w_blend;
      end else if (pix_ready_i) begin
         r_pix_valid <= 1'b0;
      end
   end

endmodule
